// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      func7,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                special_q, special_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept, is_div, sgn_a, sgn_b, special;
  logic [XLEN-1:0]     mag_a, mag_b, spec_res, fin_res;
  logic [XLEN:0]       mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0]   fast_prod;
  assign fast_prod = {{XLEN{sgn_a}}, rs1} * {{XLEN{sgn_b}}, rs2};
`endif

  // Decode of the accept request: operand signs, magnitudes and the no-iteration cases.
  always_comb begin
    accept   = (state_q == IDLE) && start && (alu_op == 2'b10) && (func7 == 7'b0000001) && !flush;
    is_div   = func3[2];
    sgn_a    = rs1[XLEN-1] & ((func3 == 3'd1) | (func3 == 3'd2) | (func3 == 3'd4) | (func3 == 3'd6));
    sgn_b    = rs2[XLEN-1] & ((func3 == 3'd1) | (func3 == 3'd4) | (func3 == 3'd6));
    mag_a    = sgn_a ? -rs1 : rs1;
    mag_b    = sgn_b ? -rs2 : rs2;
    special  = 1'b0;
    spec_res = '0;
    if (is_div && (rs2 == '0)) begin
      special  = 1'b1;
      spec_res = func3[1] ? rs1 : '1;
    end else if (is_div && !func3[0] && (rs1 == MOST_NEG) && (rs2 == '1)) begin
      special  = 1'b1;
      spec_res = func3[1] ? '0 : rs1;
    end
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div) begin
      special  = 1'b1;
      spec_res = (func3 == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
`endif
  end

  // One iteration step: multiplier sits in the low half, divisor/multiplicand in opnd_q.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, opnd_q};
    div_next = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    fin_res = '0;
    if (special_q)
      fin_res = acc_q[XLEN-1:0];
    else if (!op_q[2])
      fin_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1])
      fin_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    else
      fin_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    special_d = special_q;
    result_d  = result_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d      = func3;
        cnt_d     = '0;
        special_d = special;
        neg_d     = (func3[2] && func3[1]) ? sgn_a : (sgn_a ^ sgn_b);
        opnd_d    = is_div ? mag_b : mag_a;
        acc_d     = special ? {{XLEN{1'b0}}, spec_res} : {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
        state_d   = special ? FIN : CALC;
      end
      CALC: if (flush) begin
        state_d = IDLE;
      end else begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = FIN;
      end
      FIN: begin
        result_d = fin_res;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  // The result is driven combinationally in FIN so it is valid alongside done.
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);
  assign result = done ? fin_res : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (XLEN=32); multiply latency follows MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [6:0]  func7 = 7'h00;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .func7(func7),
    .func3(func3), .rs1(rs1), .rs2(rs2), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Launch an op from just after a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int injectAt, output logic [31:0] res, output int lat,
                        output bit busyOk);
    lat = -1; busyOk = 1'b1; res = 'x;
    start = 1'b1; alu_op = 2'b10; func7 = 7'h01; func3 = f3; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0; func3 = ~f3; rs1 = 32'hDEADBEEF; rs2 = 32'h0BADF00D;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) busyOk = 1'b0;
      if (done) begin lat = cyc; res = result; break; end
      if (cyc == injectAt) begin
        start = 1'b1; alu_op = 2'b10; func7 = 7'h01; func3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=0", result); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mul();
    logic [31:0] res; int lat; bit busyOk;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 0, res, lat, busyOk);
    checks++; if (res !== 32'hFFFFFFEB) begin failures++; $display("[TB] FAIL mul_result got=%h exp=ffffffeb", res); end
    checks++; if (lat !== MUL_LAT) begin failures++; $display("[TB] FAIL mul_latency got=%0d exp=%0d", lat, MUL_LAT); end
    checks++; if (busyOk !== 1'b1) begin failures++; $display("[TB] FAIL mul_busy_window got=%b exp=1", busyOk); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL mul_after_done busy=%b done=%b exp=0/0", busy, done); end
    checks++; if (result !== 32'hFFFFFFEB) begin failures++; $display("[TB] FAIL mul_result_held got=%h exp=ffffffeb", result); end
  endtask

  task automatic test_mulh();
    logic [31:0] res; int lat; bit busyOk;
    run_op(3'd1, 32'h80000000, 32'h80000000, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'h40000000) begin failures++; $display("[TB] FAIL mulh_min got=%h exp=40000000", res); end
    run_op(3'd3, 32'h80000000, 32'h80000000, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'h40000000) begin failures++; $display("[TB] FAIL mulhu_min got=%h exp=40000000", res); end
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL mulhsu got=%h exp=ffffffff", res); end
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'h00000000) begin failures++; $display("[TB] FAIL mulh_m1 got=%h exp=00000000", res); end
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL mulhu_max got=%h exp=fffffffe", res); end
  endtask

  task automatic test_div();
    logic [31:0] res; int lat; bit busyOk;
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'hFFFFFFFD) begin failures++; $display("[TB] FAIL div_neg got=%h exp=fffffffd", res); end
    checks++; if (lat !== DIV_LAT) begin failures++; $display("[TB] FAIL div_latency got=%0d exp=%0d", lat, DIV_LAT); end
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL rem_neg got=%h exp=ffffffff", res); end
    run_op(3'd5, 32'd100, 32'd7, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'd14) begin failures++; $display("[TB] FAIL divu got=%h exp=0000000e", res); end
    run_op(3'd7, 32'd100, 32'd7, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'd2) begin failures++; $display("[TB] FAIL remu got=%h exp=00000002", res); end
    run_op(3'd5, 32'hFFFFFFF9, 32'd2, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'h7FFFFFFC) begin failures++; $display("[TB] FAIL divu_big got=%h exp=7ffffffc", res); end
  endtask

  task automatic test_special();
    logic [31:0] res; int lat; bit busyOk;
    run_op(3'd5, 32'd5, 32'd0, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL divu_by0 got=%h exp=ffffffff", res); end
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL divu_by0_latency got=%0d exp=1", lat); end
    run_op(3'd6, 32'd5, 32'd0, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'd5) begin failures++; $display("[TB] FAIL rem_by0 got=%h exp=00000005", res); end
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'h80000000) begin failures++; $display("[TB] FAIL div_ovf got=%h exp=80000000", res); end
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL div_ovf_latency got=%0d exp=1", lat); end
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0, res, lat, busyOk); @(negedge clk);
    checks++; if (res !== 32'h0) begin failures++; $display("[TB] FAIL rem_ovf got=%h exp=00000000", res); end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat; bit busyOk; bit seenDone;
    seenDone = 1'b0;
    start = 1'b1; alu_op = 2'b10; func7 = 7'h01; func3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (done) seenDone = 1'b1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || seenDone !== 1'b0) begin failures++; $display("[TB] FAIL flush_done got=%b/%b exp=0/0", done, seenDone); end
    run_op(3'd5, 32'd100, 32'd7, 0, res, lat, busyOk);
    checks++; if (res !== 32'd14) begin failures++; $display("[TB] FAIL after_flush_result got=%h exp=0000000e", res); end
    checks++; if (lat !== DIV_LAT) begin failures++; $display("[TB] FAIL after_flush_latency got=%0d exp=%0d", lat, DIV_LAT); end
    @(negedge clk);
  endtask

  task automatic test_ignore();
    start = 1'b1; alu_op = 2'b10; func7 = 7'h00; func3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL ign_func7 busy=%b done=%b exp=0/0", busy, done); end
    start = 1'b1; alu_op = 2'b00; func7 = 7'h01;
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ign_aluop busy=%b exp=0", busy); end
    start = 1'b1; alu_op = 2'b10; func7 = 7'h01; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ign_flush_start busy=%b exp=0", busy); end
    checks++; if (result !== 32'd14) begin failures++; $display("[TB] FAIL ign_result_held got=%h exp=0000000e", result); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat; bit busyOk;
    run_op(3'd0, 32'd6, 32'd7, 5, res, lat, busyOk);
    checks++; if (res !== 32'd42) begin failures++; $display("[TB] FAIL b2b_result got=%h exp=0000002a", res); end
    checks++; if (lat !== MUL_LAT) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=%0d", lat, MUL_LAT); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second_ignored busy=%b exp=0", busy); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res; int lat; bit busyOk;
    start = 1'b1; alu_op = 2'b10; func7 = 7'h01; func3 = 3'd5; rs1 = 32'h1234; rs2 = 32'h10;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL async_rst_ctrl busy=%b done=%b exp=0/0", busy, done); end
    checks++; if (result !== 32'h0) begin failures++; $display("[TB] FAIL async_rst_result got=%h exp=00000000", result); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd0, 32'd3, 32'd4, 0, res, lat, busyOk);
    checks++; if (res !== 32'd12) begin failures++; $display("[TB] FAIL post_rst_mul got=%h exp=0000000c", res); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_ignore();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV M-extension multiply/divide execution unit, parametrised in XLEN. Decodes the same alu_op/func7/func3 fields as the ALU control path. Runs a multi-cycle shift-add multiply or restoring divide behind a start/busy/done handshake. Sits beside the ALU in EX; the pipeline stalls on busy.

Parameters:
XLEN, 32, operand/result width in bits (power of two, >= 8).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request from EX stage, qualified by decode fields
alu_op  in  2  ALU op class; M ops require 2'b10
func7  in  7  M ops require 7'b0000001
func3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1  in  XLEN  operand A (dividend / multiplicand)
rs2  in  XLEN  operand B (divisor / multiplier)
flush  in  1  synchronous abort of the in-flight op
busy  out  1  op accepted and not yet completed
done  out  1  one-cycle pulse; result valid this cycle
result  out  XLEN  op result, held until the next accept

Behaviour:
- Accept: in IDLE, when start=1 && alu_op==2'b10 && func7==7'b0000001. Operands and func3 are registered at the accept edge; later changes to the inputs have no effect.
- start with any other decode is ignored: no busy, no done.
- start while busy is ignored.
- FSM states: IDLE, CALC, FIN.
  - IDLE -> CALC on a normal accept.
  - IDLE -> FIN on a special-case accept.
  - CALC runs exactly XLEN iterations (counter 0..XLEN-1), then goes to FIN.
  - FIN -> IDLE unconditionally.
- Latency, counting the accept edge as cycle 0:
  - normal ops: done=1 in cycle XLEN+1;
  - special cases: done=1 in cycle 1.
- busy=1 from cycle 1 until the done cycle, inclusive. done=1 only in FIN.
- Multiply: signs are taken per func3 and operands converted to magnitudes. Shift-add uses a 2*XLEN product register. The product is negated if the signs differ. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring algorithm on magnitudes. Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A). DIVU/REMU are unsigned.
- Special cases, no iteration:
  - divisor==0: quotient = all ones, remainder = rs1.
  - signed overflow (rs1 = most negative, rs2 = -1): quotient = rs1, remainder = 0.
- flush=1: state goes to IDLE next edge and no done is issued. If flush coincides with FIN, done still pulses this cycle. A start in the same cycle as flush is ignored.
- Reset: all state cleared asynchronously. Outputs: busy=0, done=0, result=0, FSM=IDLE, counter=0. Reset mid-operation abandons the op.
- result updates only in FIN and holds otherwise.

Optional Feature:
MULDIV_FAST_MUL_EN.
- Defined: all four multiply ops use a single-cycle XLEN x XLEN multiplier. IDLE -> FIN directly and done=1 in cycle 1. Divide is unchanged.
- Undefined: multiplies use the iterative path with XLEN+1 latency, and no hardware multiplier is inferred.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD (XLEN=32) -> done in cycle 33 (cycle 1 with MULDIV_FAST_MUL_EN); result=0xFFFFFFEB; busy high cycles 1-33.
- MULH/MULHU: rs1=rs2=0x80000000 -> MULH 0x40000000, MULHU 0x40000000; MULHSU with rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV/REM: rs1=0xFFFFFFF9 (-7), rs2=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF; DIVU of 100/7 -> 14, REMU -> 2.
- Special cases: DIVU 5/0 -> 0xFFFFFFFF, done in cycle 1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Flush/ignore: flush in cycle 10 of a DIV -> no done, busy=0 in cycle 11, new start in cycle 11 accepted. A start with func7=0 -> busy stays 0. A second start during busy -> ignored, first result still correct.
- Async reset: assert rst_n=0 mid-CALC between clock edges -> busy, done and result are 0 immediately; after release, a MUL 3*4 returns 12.
